// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32-entry register file with one write port, two combinational read ports
//   and a per-register busy scoreboard. The scoreboard lets the pipeline stall
//   on operands whose producer has not written back yet.
//
//   Ports
//     clock             rising-edge clock
//     ctrl_reset        synchronous active-high reset (clears data and busy)
//     ctrl_writeEnable  write strobe
//     ctrl_writeReg     write address (decoded to one-hot internally)
//     data_writeReg     write data
//     ctrl_readRegA/B   read addresses
//     ctrl_setBusy      mark ctrl_busyReg as having a pending producer
//     ctrl_busyReg      register to mark busy
//     data_readRegA/B   read data (with same-cycle write-through bypass)
//     busy_A/B          operand-pending flags for ports A and B
//
//   Register 0 has no storage: it reads 0, is never busy, ignores writes.

// 5-to-32 address decoder. Line 0 does not exist because r0 has no storage,
// so an address of 0 simply produces no active line.
module regfile_decoder (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:1] lines
);

  always_comb begin
    lines = '0;
    for (int i = 1; i < 32; i++) begin
      if (en && (addr == 5'(i))) lines[i] = 1'b1;
    end
  end

endmodule

module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [4:0]            ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  input  logic                  ctrl_setBusy,
  input  logic [4:0]            ctrl_busyReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  busy_A,
  output logic                  busy_B
);

  logic [DATA_WIDTH-1:0] regs [31:1];
  logic [31:1]           busy;
  logic [31:1]           wr_lines;
  logic [31:1]           set_lines;

  // Reset gates the decoders so a write or setBusy in the reset cycle
  // cannot leak into the freshly cleared state.
  regfile_decoder u_wr_dec (
    .en    (ctrl_writeEnable & ~ctrl_reset),
    .addr  (ctrl_writeReg),
    .lines (wr_lines)
  );

  regfile_decoder u_set_dec (
    .en    (ctrl_setBusy & ~ctrl_reset),
    .addr  (ctrl_busyReg),
    .lines (set_lines)
  );

  // Storage and scoreboard update. setBusy is tested after the write so a
  // new producer issued together with a writeback to the same register
  // leaves the register marked busy.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_lines[i]) regs[i] <= data_writeReg;
        if (set_lines[i])     busy[i] <= 1'b1;
        else if (wr_lines[i]) busy[i] <= 1'b0;
      end
    end
  end

  // Port A read. A write to the same register this cycle bypasses storage
  // and clears busy, since the operand is being produced right now.
  // wr_lines is already gated by reset, so the bypass is off during reset.
  always_comb begin
    data_readRegA = '0;
    busy_A        = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_readRegA == 5'(i)) begin
        if (wr_lines[i]) begin
          data_readRegA = data_writeReg;
          busy_A        = 1'b0;
        end else begin
          data_readRegA = regs[i];
          busy_A        = busy[i];
        end
      end
    end
  end

  // Port B read, identical to port A and fully independent of it.
  always_comb begin
    data_readRegB = '0;
    busy_B        = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_readRegB == 5'(i)) begin
        if (wr_lines[i]) begin
          data_readRegB = data_writeReg;
          busy_B        = 1'b0;
        end else begin
          data_readRegB = regs[i];
          busy_B        = busy[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard. A behavioural model (plain
//   arrays of register values and busy flags) is updated on every rising edge
//   and compared against the DUT outputs on every falling edge. Directed
//   sequences with hand-computed literal expectations pin the model, then a
//   randomized run exercises collisions, bypass and reset.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        ctrl_setBusy;
  logic [4:0]  ctrl_busyReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        busy_A;
  logic        busy_B;

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  logic [31:0] mReg  [32];
  bit          mBusy [32];

  regfile_scoreboard #(.DATA_WIDTH(32)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .ctrl_setBusy     (ctrl_setBusy),
    .ctrl_busyReg     (ctrl_busyReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .busy_A           (busy_A),
    .busy_B           (busy_B)
  );

  always #5 clock = ~clock;

  // Reference model: register 0 is never written so it stays 0 / not busy.
  // setBusy is applied after the write so a same-register pair ends busy.
  always @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) begin
        mReg[i]  <= 32'h0;
        mBusy[i] <= 1'b0;
      end
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
        mReg[ctrl_writeReg]  <= data_writeReg;
        mBusy[ctrl_writeReg] <= 1'b0;
      end
      if (ctrl_setBusy && ctrl_busyReg != 5'd0) mBusy[ctrl_busyReg] <= 1'b1;
    end
  end

  function automatic bit bypassHit(input logic [4:0] a);
    return !ctrl_reset && ctrl_writeEnable && ctrl_writeReg == a && a != 5'd0;
  endfunction

  function automatic logic [31:0] expData(input logic [4:0] a);
    if (a == 5'd0)   return 32'h0;
    if (bypassHit(a)) return data_writeReg;
    return mReg[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    if (a == 5'd0 || bypassHit(a)) return 1'b0;
    return mBusy[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual,
               expected, $time);
    end
  endtask

  // Continuous model comparison on every falling edge once state is defined.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("model dataA", data_readRegA, expData(ctrl_readRegA));
      checkOutput("model dataB", data_readRegB, expData(ctrl_readRegB));
      checkOutput("model busyA", {31'h0, busy_A}, {31'h0, expBusy(ctrl_readRegA)});
      checkOutput("model busyB", {31'h0, busy_B}, {31'h0, expBusy(ctrl_readRegB)});
    end
  end

  // Drives one cycle of inputs just after the rising edge, then waits for
  // the falling edge so directed checks see the settled combinational values.
  task automatic applyStimulus(input logic rst, input logic we,
                               input logic [4:0] wr, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic sb, input logic [4:0] br);
    @(posedge clock);
    #1;
    ctrl_reset       = rst;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wr;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
    ctrl_setBusy     = sb;
    ctrl_busyReg     = br;
    @(negedge clock);
  endtask

  task automatic readPair(input logic [4:0] ra, input logic [4:0] rb);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, ra, rb, 1'b0, 5'd0);
  endtask

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    ctrl_setBusy     = 1'b0;
    ctrl_busyReg     = 5'd0;

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    checkEn = 1'b1;

    // Reset state: every address reads 0 and not busy.
    for (int a = 0; a < 32; a++) begin
      readPair(5'(a), 5'(31 - a));
      checkOutput("reset dataA", data_readRegA, 32'h0);
      checkOutput("reset dataB", data_readRegB, 32'h0);
      checkOutput("reset busyA", {31'h0, busy_A}, 32'h0);
      checkOutput("reset busyB", {31'h0, busy_B}, 32'h0);
    end

    // r0 ignores writes, including the bypass path.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    checkOutput("r0 bypass", data_readRegA, 32'h0);
    readPair(5'd0, 5'd0);
    checkOutput("r0 stored", data_readRegA, 32'h0);

    // Single write lands in r5 only.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h12345678, 5'd1, 5'd2, 1'b0, 5'd0);
    readPair(5'd5, 5'd6);
    checkOutput("r5 dataA", data_readRegA, 32'h12345678);
    checkOutput("r6 dataB", data_readRegB, 32'h0);
    for (int a = 0; a < 32; a++) begin
      readPair(5'(a), 5'(a));
      checkOutput("onehot write", data_readRegA, (a == 5) ? 32'h12345678 : 32'h0);
    end

    // Same-cycle write-through bypass on r7.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hAAAA5555, 5'd7, 5'd0, 1'b0, 5'd0);
    checkOutput("r7 bypass", data_readRegA, 32'hAAAA5555);
    readPair(5'd7, 5'd0);
    checkOutput("r7 stored", data_readRegA, 32'hAAAA5555);

    // Scoreboard sequence on r9.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9);
    checkOutput("r9 setBusy same cycle", {31'h0, busy_B}, 32'h0);
    readPair(5'd0, 5'd9);
    checkOutput("r9 busy after set", {31'h0, busy_B}, 32'h1);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h42, 5'd0, 5'd9, 1'b0, 5'd0);
    checkOutput("r9 busy bypass", {31'h0, busy_B}, 32'h0);
    checkOutput("r9 data bypass", data_readRegB, 32'h42);
    readPair(5'd0, 5'd9);
    checkOutput("r9 busy after write", {31'h0, busy_B}, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h43, 5'd0, 5'd9, 1'b1, 5'd9);
    readPair(5'd0, 5'd9);
    checkOutput("r9 data write+set", data_readRegB, 32'h43);
    checkOutput("r9 busy write+set", {31'h0, busy_B}, 32'h1);

    // Reset mid-operation: r3=0x55 busy, then reset with a write to r3.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 1'b1, 5'd3);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h99, 5'd3, 5'd0, 1'b0, 5'd0);
    checkOutput("r3 no bypass in reset", data_readRegA, 32'h55);
    checkOutput("r3 busy in reset", {31'h0, busy_A}, 32'h1);
    readPair(5'd3, 5'd9);
    checkOutput("r3 cleared", data_readRegA, 32'h0);
    checkOutput("r3 busy cleared", {31'h0, busy_A}, 32'h0);
    checkOutput("r9 cleared", data_readRegB, 32'h0);

    // Dual read of the same address.
    applyStimulus(1'b0, 1'b1, 5'd12, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
    readPair(5'd12, 5'd12);
    checkOutput("r12 dataA", data_readRegA, 32'hFFFFFFFF);
    checkOutput("r12 dataB", data_readRegB, 32'hFFFFFFFF);
    applyStimulus(1'b0, 1'b1, 5'd12, 32'h0000ABCD, 5'd12, 5'd12, 1'b1, 5'd12);
    readPair(5'd12, 5'd12);
    checkOutput("r12 busyA", {31'h0, busy_A}, 32'h1);
    checkOutput("r12 busyB", {31'h0, busy_B}, 32'h1);
    checkOutput("r12 dataA new", data_readRegA, 32'h0000ABCD);

    // Randomized run; addresses are biased to a small pool to force
    // write/read/setBusy collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] addr [4];
      for (int k = 0; k < 4; k++) begin
        addr[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3))
                                              : 5'($urandom_range(0, 31));
      end
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                    addr[0], $urandom, addr[1], addr[2],
                    1'($urandom_range(0, 1)), addr[3]);
    end

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32-entry register file with one write port and two read ports. It consumes the one-hot write-enable vector from the 5-to-32 write-address decoder, which is instantiated internally on ctrl_writeReg.
- Adds a per-register busy scoreboard so the downstream pipeline can detect pending writes and stall.
- Sits between decode/writeback and the execute-stage operand latches.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports. Address width is fixed at 5 and depth is fixed at 32.

Ports:
clock  input  1  single rising-edge clock
ctrl_reset  input  1  synchronous, active-high reset
ctrl_writeEnable  input  1  write strobe for the write port
ctrl_writeReg  input  5  write address, decoded to one-hot internally
data_writeReg  input  DATA_WIDTH  write data
ctrl_readRegA  input  5  read address, port A
ctrl_readRegB  input  5  read address, port B
ctrl_setBusy  input  1  mark ctrl_busyReg as having a pending producer
ctrl_busyReg  input  5  register to mark busy
data_readRegA  output  DATA_WIDTH  read data, port A
data_readRegB  output  DATA_WIDTH  read data, port B
busy_A  output  1  port A operand pending
busy_B  output  1  port B operand pending

Behaviour:
- Storage: regs[31:1] of DATA_WIDTH bits plus busy[31:1]. Register 0 has no storage: it reads 0, is never busy, and writes or setBusy targeting it are ignored.
- Reset, sampled at the rising edge with ctrl_reset=1:
  - all regs and all busy bits cleared to 0;
  - a write or setBusy in the same cycle is ignored (reset wins).
- After the reset edge: data_readRegA/B=0 and busy_A/B=0 for every address until a write occurs.
- Write, at the edge with ctrl_writeEnable=1, reset=0, ctrl_writeReg!=0:
  - regs[ctrl_writeReg] <= data_writeReg;
  - busy[ctrl_writeReg] <= 0.
  - Only the decoder's one-hot line for ctrl_writeReg is gated; no other register changes.
- setBusy, at the edge with ctrl_setBusy=1, reset=0, ctrl_busyReg!=0: busy[ctrl_busyReg] <= 1.
- Write and setBusy to the same register in the same cycle: the data is written and the busy bit ends up 1 (the new producer wins).
- Write and setBusy to different registers in the same cycle: both take effect independently.
- Reads are combinational from the read address, with zero-cycle latency.
- Write-through bypass applies when ctrl_reset=0, ctrl_writeEnable=1, ctrl_writeReg==ctrl_readRegX and ctrl_readRegX!=0:
  - data_readRegX = data_writeReg (the current-cycle value);
  - busy_X = 0, because the operand is being produced now.
- Otherwise: data_readRegX = regs[ctrl_readRegX] and busy_X = busy[ctrl_readRegX].
- setBusy issued in the current cycle has no combinational effect on busy_X; it becomes visible the cycle after the edge.
- Bypass is disabled while ctrl_reset=1. Reads then show the stored contents; the cleared state is visible after the edge.
- Ports A and B are fully independent and may carry the same address; both then return identical data and busy.
- Out-of-range addresses cannot occur (5-bit address, 32 entries). No X-propagation from unwritten registers, since reset initialises all state.

Test Plan:
- Reset, then read every address 0..31 on A and B -> all data 0 and busy 0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write 0x12345678 to r5. Next cycle, read A=5 and B=6 -> A=0x12345678, B=0. Verify no other register changed across all 32 addresses (one-hot write check).
- Same-cycle bypass: r7 holds 0x1. Write 0xAAAA5555 to r7 while A=7 -> data_readRegA=0xAAAA5555 in that same cycle. Next cycle the stored value is 0xAAAA5555.
- Scoreboard sequence:
  - setBusy r9 -> next cycle busy_B=1 with B=9;
  - then write r9=0x42 -> busy_B=0 in the write cycle (bypass) and remains 0 after.
  - Simultaneous setBusy r9 and write r9=0x43 -> next cycle data 0x43, busy_B=1.
- Reset mid-operation: r3=0x55 and busy[3]=1. Assert reset together with a write r3=0x99 -> during the cycle, A=3 reads 0x55 with no bypass. After the edge, r3=0, busy_A=0, and the write is discarded.
- Dual read of the same address: A=B=12 after r12=0xFFFFFFFF -> both ports return 0xFFFFFFFF. With both write and setBusy to r12 the next cycle -> both ports show busy after that edge.
